// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder around one full-adder cell (optional subtract via SERIAL_ADDER_SUB_EN)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic             load;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;

  // the single full-adder cell fed from the operand LSBs and the carry flop
  always_comb begin
    fa_s = a_sr[0] ^ b_sr[0] ^ carry;
    fa_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  end

  // operand/carry values captured on the accepting edge
  always_comb begin
    b_ld = b;
    c_ld = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_ld = ~b;
      c_ld = 1'b1;
    end
`endif
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state, load strobe and status outputs
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // datapath: load operands, then shift one bit per clock through the cell
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b_ld;
      carry <= c_ld;
      cnt   <= '0;
      cout  <= 1'b0;
    end else if (state == SHIFT) begin
      sum   <= {fa_s, sum[WIDTH-1:1]};
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
      if (cnt == LAST) cout <= fa_c;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed vector bench for serial_adder
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;

  int total = 0;
  int bad = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic do_op(input string name, input logic [7:0] va, input logic [7:0] vb,
                       input logic vc, input logic vs, input logic [7:0] es, input logic eco);
    int n, nbusy;
    bit got;
    @(negedge clk);
    a = va; b = vb; cin = vc; sub = vs; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; nbusy = 0; got = 0;
    while (!got && n < 20) begin
      n++;
      if (busy) nbusy++;
      if (done) got = 1;
      else @(negedge clk);
    end
    check({name, " sum"}, sum, es);
    check({name, " cout"}, cout, eco);
    check({name, " latency"}, n, 9);
    check({name, " busy_cycles"}, nbusy, 8);
    @(negedge clk);
    check({name, " done_single"}, done, 0);
  endtask

  initial begin
    int ndone, idle_cyc;
    int first_i;
    logic [7:0] s_at;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst sum", sum, 0);
    check("rst cout", cout, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].s, vecs[i].co);

    // start while busy is ignored
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; s_at = 8'hxx;
    for (int i = 0; i < 20; i++) begin
      if (done) begin ndone++; s_at = sum; end
      if (i == 3) begin a = 8'hF0; b = 8'h0F; start = 1'b1; end
      if (i == 4) start = 1'b0;
      @(negedge clk);
    end
    check("ignore ndone", ndone, 1);
    check("ignore sum", s_at, 8'h02);

    // back-to-back with start held
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    ndone = 0; idle_cyc = 0; first_i = -1;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        ndone++;
        if (first_i < 0) first_i = i;
        else check("b2b spacing", i - first_i, 9 * (ndone - 1));
        check("b2b sum", sum, 8'h30);
        check("b2b cout", cout, 0);
      end
      if (!busy && !done) idle_cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b ndone", ndone, 3);
    check("b2b first", first_i, 8);
    check("b2b idle", idle_cyc, 0);
    begin
      int k = 0;
      while ((busy || done) && k < 20) begin k++; @(negedge clk); end
      check("b2b drain", busy || done, 0);
    end

    // asynchronous reset mid-operation
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-rst busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst busy", busy, 0);
    check("arst done", done, 0);
    check("arst sum", sum, 0);
    check("arst cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    check("post-rst quiet", ndone, 0);
    do_op("after rst", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op("sub 10-20", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0);
    do_op("sub 20-10", 8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1);
    do_op("sub0 add", 8'h20, 8'h10, 1'b1, 1'b0, 8'h31, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
